// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    localparam int         DEF_TIMEOUT = 64;
    localparam int         DEF_CNT_W   = 16;
    localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, memory handshake and pipeline enables of the stall/flush sequencer.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RegisterRt_i;
    logic [4:0]       IFID_RegisterRs_i;
    logic [4:0]       IFID_RegisterRt_i;
    logic             Branch_taken_i;
    logic             Jump_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             IFIDFlush_o;
    logic             IDEXBubble_o;
    logic             pipe_stall_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Pipeline side: supplies hazard/memory status, consumes enables.
    modport master (
        output IDEX_MemRead_i, IDEX_RegisterRt_i, IFID_RegisterRs_i, IFID_RegisterRt_i,
        output Branch_taken_i, Jump_i, dmem_req_i, dmem_ack_i,
        input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, pipe_stall_o,
        input  err_o, stall_cnt_o, flush_cnt_o
    );

    // Sequencer side.
    modport slave (
        input  IDEX_MemRead_i, IDEX_RegisterRt_i, IFID_RegisterRs_i, IFID_RegisterRt_i,
        input  Branch_taken_i, Jump_i, dmem_req_i, dmem_ack_i,
        output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, pipe_stall_o,
        output err_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use, branch/jump and multi-cycle memory
// stalls into one set of pipeline enables, with a memory watchdog and perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_ctrl_if.slave       bus
);
    // Wait counter only needs to reach TIMEOUT-1.
    localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    ctrl_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic             err;
    logic             mem_stall;
    logic             load_use;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_stall;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign mem_stall = bus.dmem_req_i && !bus.dmem_ack_i;
    assign load_use  = bus.IDEX_MemRead_i && (bus.IDEX_RegisterRt_i != REG_ZERO) &&
                       ((bus.IDEX_RegisterRt_i == bus.IFID_RegisterRs_i) ||
                        (bus.IDEX_RegisterRt_i == bus.IFID_RegisterRt_i));

    // Priority resolution of the enables; reset, HALT and a pending memory wait all freeze.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_stall  = 1'b1;
        if (rst_i && (state != HALT) && !mem_stall) begin
            pipe_stall = 1'b0;
            if (load_use) begin
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = bus.Branch_taken_i || bus.Jump_i;
            end
        end
    end

    // Sequencer FSM with watchdog: the RUN cycle that starts a wait is not counted,
    // HALT is taken on the TIMEOUT-th stalled cycle spent in MEM_WAIT.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= HALT;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (!pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (ifid_flush),
        .count (flush_cnt)
    );

    assign bus.PCWrite_o    = pc_write;
    assign bus.IFIDWrite_o  = ifid_write;
    assign bus.IFIDFlush_o  = ifid_flush;
    assign bus.IDEXBubble_o = idex_bubble;
    assign bus.pipe_stall_o = pipe_stall;
    assign bus.err_o        = err;
    assign bus.stall_cnt_o  = stall_cnt;
    assign bus.flush_cnt_o  = flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: halt flag, length of the current unbroken memory-stall run,
    // sticky error and plain integer counts clipped at CNT_MAX.
    bit m_halt;
    bit m_err;
    int m_run;
    int m_stalls;
    int m_flushes;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare all outputs mid-cycle, then advance the model.
    task automatic step(input bit rst, input bit mr, input int rt_ex, input int rs_id,
                        input int rt_id, input bit br, input bit jmp, input bit req, input bit ack);
        bit stall_mem, lu, frz;
        bit e_pc, e_ifid, e_fl, e_bub, e_ps;
        rst_i                 = rst;
        bus.IDEX_MemRead_i    = mr;
        bus.IDEX_RegisterRt_i = 5'(rt_ex);
        bus.IFID_RegisterRs_i = 5'(rs_id);
        bus.IFID_RegisterRt_i = 5'(rt_id);
        bus.Branch_taken_i    = br;
        bus.Jump_i            = jmp;
        bus.dmem_req_i        = req;
        bus.dmem_ack_i        = ack;
        @(negedge clk_i);
        if (!rst) begin
            m_halt = 0; m_err = 0; m_run = 0; m_stalls = 0; m_flushes = 0;
        end
        stall_mem = req && !ack;
        lu  = mr && (rt_ex != 0) && (rt_ex == rs_id || rt_ex == rt_id);
        frz = !rst || m_halt || stall_mem;
        e_ps   = frz;
        e_bub  = !frz && lu;
        e_pc   = !frz && !lu;
        e_ifid = e_pc;
        e_fl   = e_pc && (br || jmp);
        chk("PCWrite",    int'(bus.PCWrite_o),    int'(e_pc));
        chk("IFIDWrite",  int'(bus.IFIDWrite_o),  int'(e_ifid));
        chk("IFIDFlush",  int'(bus.IFIDFlush_o),  int'(e_fl));
        chk("IDEXBubble", int'(bus.IDEXBubble_o), int'(e_bub));
        chk("pipe_stall", int'(bus.pipe_stall_o), int'(e_ps));
        chk("err",        int'(bus.err_o),        int'(m_err));
        chk("stall_cnt",  int'(bus.stall_cnt_o),  m_stalls);
        chk("flush_cnt",  int'(bus.flush_cnt_o),  m_flushes);
        if (rst) begin
            if (!e_pc && m_stalls < CNT_MAX) m_stalls++;
            if (e_fl && m_flushes < CNT_MAX) m_flushes++;
            if (!m_halt) begin
                if (stall_mem) begin
                    m_run++;
                    if (m_run == TIMEOUT + 1) begin
                        m_halt = 1;
                        m_err  = 1;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.IDEX_MemRead_i = 0; bus.IDEX_RegisterRt_i = 0; bus.IFID_RegisterRs_i = 0;
        bus.IFID_RegisterRt_i = 0; bus.Branch_taken_i = 0; bus.Jump_i = 0;
        bus.dmem_req_i = 0; bus.dmem_ack_i = 0;
        m_halt = 0; m_err = 0; m_run = 0; m_stalls = 0; m_flushes = 0;
        @(posedge clk_i);
        #1;
        do_reset();
        idle(1);

        // Load-use on rs, then with Rt = 0
        step(1, 1, 5, 5, 9, 0, 0, 0, 0);
        idle(1);
        chk("lu_stall_cnt", int'(bus.stall_cnt_o), 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_r0_stall_cnt", int'(bus.stall_cnt_o), 1);

        // Three-cycle memory wait, then single-cycle access
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("mem3_stall_cnt", int'(bus.stall_cnt_o), 4);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        chk("mem1_stall_cnt", int'(bus.stall_cnt_o), 4);

        // Branch alone, then jump held across a memory wait
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("br_flush_cnt", int'(bus.flush_cnt_o), 1);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("jmp_wait_flush_cnt", int'(bus.flush_cnt_o), 1);
        step(1, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("jmp_ack_flush_cnt", int'(bus.flush_cnt_o), 2);

        // Load-use together with a branch: bubble first, flush next
        step(1, 1, 7, 3, 7, 1, 0, 0, 0);
        step(1, 0, 7, 3, 7, 1, 0, 0, 0);
        chk("lu_br_flush_cnt", int'(bus.flush_cnt_o), 3);
        chk("lu_br_stall_cnt", int'(bus.stall_cnt_o), 7);

        // Reset in the middle of a memory wait
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_wait_stall_cnt", int'(bus.stall_cnt_o), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Watchdog: request never acknowledged
        for (int i = 0; i < TIMEOUT + 1; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("wd_err", int'(bus.err_o), 1);
        step(1, 0, 0, 0, 0, 1, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wd_halt_pcwrite", int'(bus.PCWrite_o), 0);
        do_reset();
        chk("wd_rst_err", int'(bus.err_o), 0);
        idle(1);

        // Counter saturation
        for (int i = 0; i < 20; i++) step(1, 1, 4, 4, 0, 0, 0, 0, 0);
        chk("sat_stall_cnt", int'(bus.stall_cnt_o), CNT_MAX);
        do_reset();

        // Randomized traffic with small register numbers so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            bit r, mr, br, jmp, req, ack;
            r   = ($urandom_range(0, 99) >= 2);
            mr  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 4) == 0);
            jmp = ($urandom_range(0, 7) == 0);
            req = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 1) == 0);
            step(r, mr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 br, jmp, req, ack);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges three stall sources into one consistent set of pipeline-register enables each cycle: load-use hazards, taken branches/jumps resolved in ID, and multi-cycle data-memory accesses signalled by a req/ack handshake. It sits beside the ID stage and drives the PC, IF/ID, ID/EX-bubble mux and the EX/MEM–MEM/WB freeze. It also runs a memory watchdog and saturating stall/flush performance counters.

## Interface
- TIMEOUT, 64, max consecutive unacknowledged memory-wait cycles before halt (≥2)
- CNT_W, 16, width of performance counters
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_RegisterRt_i  in  5  load destination in EX
- IFID_RegisterRs_i  in  5  rs of instruction in ID
- IFID_RegisterRt_i  in  5  rt of instruction in ID
- Branch_taken_i  in  1  branch in ID resolved taken
- Jump_i  in  1  jump in ID
- dmem_req_i  in  1  MEM stage has an access outstanding
- dmem_ack_i  in  1  data memory completes access this cycle
- PCWrite_o  out  1  1 = PC loads next value
- IFIDWrite_o  out  1  1 = IF/ID register loads
- IFIDFlush_o  out  1  1 = IF/ID loads a NOP
- IDEXBubble_o  out  1  1 = ID/EX control fields zeroed
- pipe_stall_o  out  1  1 = ID/EX, EX/MEM, MEM/WB hold
- err_o  out  1  sticky watchdog error
- stall_cnt_o  out  CNT_W  cycles with PCWrite_o = 0 (saturating)
- flush_cnt_o  out  CNT_W  cycles with IFIDFlush_o = 1 (saturating)

## Operation
- States: RUN, MEM_WAIT, HALT.
- mem_stall = dmem_req_i && !dmem_ack_i.
- load_use = IDEX_MemRead_i && IDEX_RegisterRt_i != 0 && (Rt == IFID_Rs || Rt == IFID_Rt).
- Output priority, evaluated combinationally from the current state and inputs, first match wins:
  1. HALT: PCWrite=0, IFIDWrite=0, pipe_stall=1, flush=0, bubble=0.
  2. mem_stall: same as HALT. Load-use and branch are ignored and re-evaluated once the access completes.
  3. load_use: PCWrite=0, IFIDWrite=0, IDEXBubble=1, pipe_stall=0. A branch held in ID is not flushed.
  4. Branch_taken_i || Jump_i: IFIDFlush=1, PCWrite=1, IFIDWrite=1.
  5. Otherwise: PCWrite=1, IFIDWrite=1, all others 0.
- Transitions:
  - RUN→MEM_WAIT on mem_stall.
  - MEM_WAIT→RUN on dmem_ack_i, or when dmem_req_i drops.
  - MEM_WAIT→HALT when mem_stall holds in the TIMEOUT-th consecutive wait cycle; err_o←1 on the same edge.
  - HALT is left only by reset.
- Wait counter: cleared on entry to MEM_WAIT and in RUN, incremented each mem_stall cycle.
- Ack cycle: the pipeline advances under priorities 3–5. A single-cycle access (ack with req) costs 0 stall cycles.
- Counters: increment by 1 at the clock edge ending a qualifying cycle, and hold at 2^CNT_W−1.

## Timing
- Enables are combinational, with zero-cycle latency from inputs. State, wait counter, err_o and perf counters are registered.
- While rst_i = 0: state=RUN, wait counter=0, err_o=0, stall_cnt_o=0, flush_cnt_o=0. Enables are forced to PCWrite=0, IFIDWrite=0, pipe_stall=1, flush=0, bubble=0, and stall_cnt does not count.
- Reset deassertion takes effect at the first rising edge after rst_i rises. Reset asserted mid-MEM_WAIT or in HALT returns to RUN immediately.
- A memory access of N≥1 cycles before ack yields exactly N stall cycles.
- Load-use yields exactly 1 stall cycle, because the bubble clears IDEX_MemRead_i on the next cycle.
- Load-use and a branch in the same cycle: one stall cycle, then the flush on the following cycle.

## Structure
- Package pipeline_ctrl_pkg:
  - state enum (RUN, MEM_WAIT, HALT)
  - default TIMEOUT and CNT_W constants
  - register-zero constant 5'd0
- Sub-module sat_counter (width parameter, inc, count), instantiated twice for the perf counters.
- The FSM, wait counter and priority logic live in pipeline_ctrl.

## Test plan
- Load-use: IDEX_MemRead=1, Rt=5, IFID_Rs=5 → PCWrite=0, IFIDWrite=0, IDEXBubble=1 for 1 cycle; stall_cnt_o=1. Repeating with Rt=0 → no stall.
- Memory wait: req high and ack after 3 cycles → pipe_stall=1 for exactly 3 cycles, state returns to RUN, stall_cnt_o=3. Req and ack in the same cycle → 0 stalls.
- Branch: Branch_taken_i=1 alone → IFIDFlush=1, PCWrite=1, flush_cnt_o=1. Jump_i during mem_stall → no flush until the ack cycle.
- Simultaneous load-use and branch → cycle 1 bubble only, cycle 2 flush.
- Watchdog with TIMEOUT=4 and req held without ack → HALT after 4 wait cycles, err_o=1, all enables frozen. A later ack has no effect; rst_i low → err_o=0, RUN.
- Saturation with CNT_W=4 and 20 stall cycles → stall_cnt_o=15. Reset asserted during MEM_WAIT → enables forced to the reset values immediately and the counters clear.
